// File: rtl/nmea_sentence_parser.sv
// nmea_sentence_parser
//   Frames NMEA sentences ('$' body '*' HH) from the UART byte stream, checks
//   the XOR checksum, classifies the sentence type and replays the body of
//   valid, enabled sentences as a tagged byte stream under valid/ready.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_new, rx_data   one-cycle strobe qualifying the received byte
//   out_valid/ready   replay handshake
//   out_data          body byte being replayed
//   out_field         field index of out_data (a comma carries the field it ends)
//   out_delim         out_data is ','
//   out_last          final body byte
//   out_type          0=unknown 1=GGA 2=VTG 3=RMC 4=GSA
//   err_checksum      one-cycle pulse, checksum mismatch
//   err_overflow      one-cycle pulse, body longer than MAX_LEN
//   err_format        one-cycle pulse, CR/LF in body, non-hex checksum, empty body
//   ok_cnt            count of checksum-valid sentences (wraps)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | hunting for '$'
// SAVE    | storing body bytes and accumulating the XOR checksum
// CK_HI   | waiting for the high checksum nibble
// CK_LO   | waiting for the low checksum nibble
// CHECK   | one cycle: compare checksum, classify, decide on replay
// REPLAY  | streaming the buffered body downstream
module nmea_sentence_parser #(
   parameter int         MAX_LEN        = 82,
   parameter int         FIELD_W        = 5,
   parameter logic [4:0] TYPE_MASK      = 5'b00110,
   parameter bit         ACCEPT_UNKNOWN = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx_new,
   input  logic [7:0]         rx_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_data,
   output logic [FIELD_W-1:0] out_field,
   output logic               out_delim,
   output logic               out_last,
   output logic [2:0]         out_type,
   output logic               err_checksum,
   output logic               err_overflow,
   output logic               err_format,
   output logic [15:0]        ok_cnt
);

   localparam int                 CW        = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0]      LEN_MAX   = CW'(MAX_LEN);
   localparam logic [FIELD_W-1:0] FIELD_SAT = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_SAVE, S_CK_HI, S_CK_LO, S_CHECK, S_REPLAY
   } state_t;

   state_t             state, state_nxt;
   logic [7:0]         mem [MAX_LEN];
   logic [CW-1:0]      count, rd;
   logic [7:0]         csum;
   logic [3:0]         ck_hi, ck_lo;
   logic [FIELD_W-1:0] field;
   logic [2:0]         typ;
   logic [15:0]        ok_q;

   logic               is_dollar, is_star, is_eol, is_hex;
   logic [3:0]         hex_val;
   logic [2:0]         sent_type;
   logic               type_en, csum_match, rd_last, mem_we;
   logic [7:0]         rd_byte;
   logic               err_cs_nxt, err_ov_nxt, err_fm_nxt;

   assign is_dollar = (rx_data == 8'h24);
   assign is_star   = (rx_data == 8'h2A);
   assign is_eol    = (rx_data == 8'h0D) || (rx_data == 8'h0A);

   // 'A'..'F' and 'a'..'f' share a low nibble of 1..6, so +9 gives 10..15
   always_comb begin
      is_hex  = 1'b0;
      hex_val = 4'h0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         is_hex  = 1'b1;
         hex_val = rx_data[3:0];
      end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                   (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
         is_hex  = 1'b1;
         hex_val = rx_data[3:0] + 4'd9;
      end
   end

   // Sentence type lives in body bytes 2..4 (after the talker id)
   always_comb begin
      sent_type = 3'd0;
      if (count >= CW'(5)) begin
         case ({mem[2], mem[3], mem[4]})
            24'h474741: sent_type = 3'd1;  // GGA
            24'h565447: sent_type = 3'd2;  // VTG
            24'h524D43: sent_type = 3'd3;  // RMC
            24'h475341: sent_type = 3'd4;  // GSA
            default:    sent_type = 3'd0;
         endcase
      end
   end

   assign type_en    = TYPE_MASK[sent_type] || (sent_type == 3'd0 && ACCEPT_UNKNOWN);
   assign csum_match = ({ck_hi, ck_lo} == csum);
   assign rd_byte    = mem[rd];
   assign rd_last    = (rd == count - CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      err_cs_nxt = 1'b0;
      err_ov_nxt = 1'b0;
      err_fm_nxt = 1'b0;
      mem_we     = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_new && is_dollar) state_nxt = S_SAVE;
         end
         S_SAVE: begin
            if (rx_new) begin
               if (is_dollar) begin
                  state_nxt = S_SAVE;
               end else if (is_star) begin
                  state_nxt = S_CK_HI;
               end else if (is_eol) begin
                  err_fm_nxt = 1'b1;
                  state_nxt  = S_IDLE;
               end else if (count == LEN_MAX) begin
                  err_ov_nxt = 1'b1;
                  state_nxt  = S_IDLE;
               end else begin
                  mem_we = 1'b1;
               end
            end
         end
         S_CK_HI: begin
            if (rx_new) begin
               if (is_hex) begin
                  state_nxt = S_CK_LO;
               end else begin
                  err_fm_nxt = 1'b1;
                  state_nxt  = S_IDLE;
               end
            end
         end
         S_CK_LO: begin
            if (rx_new) begin
               if (is_hex) begin
                  state_nxt = S_CHECK;
               end else begin
                  err_fm_nxt = 1'b1;
                  state_nxt  = S_IDLE;
               end
            end
         end
         S_CHECK: begin
            if (count == '0) begin
               err_fm_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end else if (!csum_match) begin
               err_cs_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end else if (type_en) begin
               state_nxt = S_REPLAY;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_REPLAY: begin
            if (out_ready && rd_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Body storage has no reset; its contents only matter after a fresh SAVE
   always_ff @(posedge clk) begin
      if (mem_we) mem[count] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count        <= '0;
         csum         <= 8'h00;
         ck_hi        <= 4'h0;
         ck_lo        <= 4'h0;
         rd           <= '0;
         field        <= '0;
         typ          <= 3'd0;
         ok_q         <= 16'h0000;
         err_checksum <= 1'b0;
         err_overflow <= 1'b0;
         err_format   <= 1'b0;
      end else begin
         err_checksum <= err_cs_nxt;
         err_overflow <= err_ov_nxt;
         err_format   <= err_fm_nxt;
         case (state)
            S_IDLE: begin
               if (rx_new && is_dollar) begin
                  count <= '0;
                  csum  <= 8'h00;
               end
            end
            S_SAVE: begin
               if (rx_new && is_dollar) begin
                  count <= '0;
                  csum  <= 8'h00;
               end else if (mem_we) begin
                  csum  <= csum ^ rx_data;
                  count <= count + CW'(1);
               end
            end
            S_CK_HI: if (rx_new && is_hex) ck_hi <= hex_val;
            S_CK_LO: if (rx_new && is_hex) ck_lo <= hex_val;
            S_CHECK: begin
               if (count != '0 && csum_match) begin
                  ok_q  <= ok_q + 16'd1;
                  typ   <= sent_type;
                  rd    <= '0;
                  field <= '0;
               end
            end
            S_REPLAY: begin
               if (out_ready) begin
                  rd <= rd + CW'(1);
                  if (rd_byte == 8'h2C && field != FIELD_SAT) field <= field + FIELD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (state == S_REPLAY);
   assign out_data  = out_valid ? rd_byte : 8'h00;
   assign out_field = field;
   assign out_delim = out_valid && (rd_byte == 8'h2C);
   assign out_last  = out_valid && rd_last;
   assign out_type  = typ;
   assign ok_cnt    = ok_q;

endmodule

// File: tb/tb_nmea_sentence_parser.sv
module tb_nmea_sentence_parser;
   localparam int         MAX_LEN = 82;
   localparam logic [4:0] MASK_A  = 5'b00110;
   localparam logic [4:0] MASK_B  = 5'b00010;

   logic       clk = 1'b0, rst_n = 1'b0, rx_new = 1'b0, rdy_a = 1'b1;
   logic [7:0] rx_data = 8'h00;

   logic       valid_a, delim_a, last_a, cs_a, ov_a, fm_a;
   logic [7:0] data_a;
   logic [4:0] field_a;
   logic [2:0] type_a;
   logic [15:0] ok_a;
   logic       valid_b, delim_b, last_b, cs_b, ov_b, fm_b;
   logic [7:0] data_b;
   logic [4:0] field_b;
   logic [2:0] type_b;
   logic [15:0] ok_b;

   int          n_checks = 0, n_errors = 0;
   int          rdy_mode = 0, gap_max = 2;
   logic [17:0] qa[$], qb[$];
   int          ea[$], eb[$];
   logic [15:0] m_ok = 16'h0;
   logic [17:0] prev_a;
   bit          hold_a = 1'b0;

   nmea_sentence_parser u_a (
      .clk(clk), .rst_n(rst_n), .rx_new(rx_new), .rx_data(rx_data),
      .out_valid(valid_a), .out_ready(rdy_a), .out_data(data_a), .out_field(field_a),
      .out_delim(delim_a), .out_last(last_a), .out_type(type_a),
      .err_checksum(cs_a), .err_overflow(ov_a), .err_format(fm_a), .ok_cnt(ok_a));

   nmea_sentence_parser #(.TYPE_MASK(MASK_B)) u_b (
      .clk(clk), .rst_n(rst_n), .rx_new(rx_new), .rx_data(rx_data),
      .out_valid(valid_b), .out_ready(1'b1), .out_data(data_b), .out_field(field_b),
      .out_delim(delim_b), .out_last(last_b), .out_type(type_b),
      .err_checksum(cs_b), .err_overflow(ov_b), .err_format(fm_b), .ok_cnt(ok_b));

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic bit hexc(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
   endfunction

   function automatic int hexv(input logic [7:0] c);
      if (c <= "9") return int'(c) - 48;
      if (c <= "F") return int'(c) - 55;
      return int'(c) - 87;
   endfunction

   function automatic void push_err(input int k);
      ea.push_back(k);
      eb.push_back(k);
   endfunction

   function automatic void model_check(input logic [7:0] body[$], input int ck);
      logic [7:0]  x;
      logic [23:0] tname;
      int          t, f;
      bit          en_a, en_b;
      if (body.size() == 0) begin push_err(3); return; end
      x = 8'h00;
      foreach (body[i]) x ^= body[i];
      if (int'(x) != ck) begin push_err(1); return; end
      m_ok++;
      t = 0;
      if (body.size() >= 5) begin
         tname = {body[2], body[3], body[4]};
         if (tname == "GGA") t = 1;
         else if (tname == "VTG") t = 2;
         else if (tname == "RMC") t = 3;
         else if (tname == "GSA") t = 4;
      end
      en_a = MASK_A[t];
      en_b = MASK_B[t];
      f = 0;
      foreach (body[i]) begin
         logic [17:0] b;
         b = {3'(t), (i == body.size() - 1), (body[i] == ","), 5'(f), body[i]};
         if (en_a) qa.push_back(b);
         if (en_b) qb.push_back(b);
         if (body[i] == "," && f < 31) f++;
      end
   endfunction

   function automatic void model_stream(input string s);
      int phase = 0, ck = 0;
      logic [7:0] body[$];
      logic [7:0] c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         case (phase)
            0: if (c == "$") begin body.delete(); phase = 1; end
            1: begin
               if (c == "$") body.delete();
               else if (c == "*") phase = 2;
               else if (c == 8'h0D || c == 8'h0A) begin push_err(3); phase = 0; end
               else if (body.size() == MAX_LEN) begin push_err(2); phase = 0; end
               else body.push_back(c);
            end
            2: if (hexc(c)) begin ck = hexv(c) * 16; phase = 3; end
               else begin push_err(3); phase = 0; end
            default: begin
               if (hexc(c)) model_check(body, ck + hexv(c));
               else push_err(3);
               phase = 0;
            end
         endcase
      end
   endfunction

   // ---------------- monitor / scoreboard ----------------
   function automatic void check_beat(input int inst, input logic [17:0] act);
      logic [17:0] exp;
      n_checks++;
      if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
         n_errors++;
         $display("FAIL beat_unexpected inst%0d: got %0h expected none", inst, act);
         return;
      end
      exp = (inst == 0) ? qa.pop_front() : qb.pop_front();
      if (act !== exp) begin
         n_errors++;
         $display("FAIL beat inst%0d: got type/last/delim/field/data %0h expected %0h", inst, act, exp);
      end
   endfunction

   function automatic void check_err(input int inst, input logic cs, input logic ov, input logic fm);
      int n, k, e;
      n = int'(cs) + int'(ov) + int'(fm);
      if (n == 0) return;
      k = cs ? 1 : (ov ? 2 : 3);
      n_checks++;
      if (n > 1) begin
         n_errors++;
         $display("FAIL err_exclusive inst%0d: got %0d pulses expected 1", inst, n);
      end
      if ((inst == 0 && ea.size() == 0) || (inst == 1 && eb.size() == 0)) begin
         n_errors++;
         $display("FAIL err_unexpected inst%0d: got kind %0d expected none", inst, k);
         return;
      end
      e = (inst == 0) ? ea.pop_front() : eb.pop_front();
      if (k != e) begin
         n_errors++;
         $display("FAIL err_kind inst%0d: got %0d expected %0d", inst, k, e);
      end
   endfunction

   always @(negedge clk) begin
      logic [17:0] cur_a;
      if (!rst_n) begin
         hold_a = 1'b0;
      end else begin
         cur_a = {type_a, last_a, delim_a, field_a, data_a};
         if (hold_a) begin
            n_checks++;
            if (!valid_a || cur_a !== prev_a) begin
               n_errors++;
               $display("FAIL hold_stable: got valid %0b beat %0h expected valid 1 beat %0h",
                        valid_a, cur_a, prev_a);
            end
         end
         if (valid_a && rdy_a) check_beat(0, cur_a);
         if (valid_b) check_beat(1, {type_b, last_b, delim_b, field_b, data_b});
         hold_a = valid_a && !rdy_a;
         prev_a = cur_a;
         check_err(0, cs_a, ov_a, fm_a);
         check_err(1, cs_b, ov_b, fm_b);
      end
   end

   initial forever begin
      @(posedge clk); #1;
      case (rdy_mode)
         0: rdy_a = 1'b1;
         1: rdy_a = 1'($urandom_range(0, 1));
         2: rdy_a = ~rdy_a;
         default: rdy_a = 1'b0;
      endcase
   end

   // ---------------- stimulus ----------------
   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         rx_data = s[i];
         rx_new  = 1'b1;
         @(posedge clk); #1;
         rx_new  = 1'b0;
         repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic finish_sentence();
      int t = 0;
      while ((qa.size() + qb.size() + ea.size() + eb.size()) != 0 && t < 4000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_in_time", 32'(t < 4000), 32'd1);
      repeat (4) begin @(posedge clk); #1; end
      chk("ok_cnt_a", 32'(ok_a), 32'(m_ok));
      chk("ok_cnt_b", 32'(ok_b), 32'(m_ok));
      chk("idle_valid_a", 32'(valid_a), 32'd0);
   endtask

   task automatic run(input string s);
      model_stream(s);
      send_str(s);
      finish_sentence();
   endtask

   function automatic logic [7:0] xsum(input string b);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < b.len(); i++) x ^= b[i];
      return x;
   endfunction

   function automatic string sentence(input string b, input bit lower, input logic [7:0] flip);
      logic [7:0] ck = xsum(b) ^ flip;
      if (lower) return $sformatf("$%s*%02x", b, ck);
      return $sformatf("$%s*%02X", b, ck);
   endfunction

   function automatic string rand_body();
      string b, cs;
      int nf, nc;
      cs = "0123456789.NEW";
      case ($urandom_range(0, 4))
         0: b = "GPGGA";
         1: b = "GPVTG";
         2: b = "GPRMC";
         3: b = "GNGSA";
         default: b = "GPZDA";
      endcase
      nf = $urandom_range(0, 5);
      for (int f = 0; f < nf; f++) begin
         b = {b, ","};
         nc = $urandom_range(0, 6);
         for (int k = 0; k < nc; k++) b = $sformatf("%s%c", b, cs[$urandom_range(0, 13)]);
      end
      return b;
   endfunction

   function automatic string rand_sentence();
      string b, s;
      bit lo;
      b  = rand_body();
      lo = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
         0: s = sentence(b, lo, 8'h01 << $urandom_range(0, 7));
         1: s = {"$", b, "*4Z"};
         2: s = {"$", b, "\r\n"};
         3: s = {"$GP", sentence(b, lo, 8'h00)};
         4: s = sentence("GP", lo, 8'h00);
         5: s = "$*00";
         6: s = {"xy,\n", sentence(b, lo, 8'h00)};
         7: begin
            s = "$";
            for (int i = 0; i < MAX_LEN + 1 + int'($urandom_range(0, 2)); i++) s = {s, "X"};
         end
         default: s = sentence(b, lo, 8'h00);
      endcase
      return s;
   endfunction

   initial begin
      string s;
      int t;
      #12;
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_data", 32'(data_a), 32'd0);
      chk("rst_field", 32'(field_a), 32'd0);
      chk("rst_type", 32'(type_a), 32'd0);
      chk("rst_errs", 32'({cs_a, ov_a, fm_a}), 32'd0);
      chk("rst_ok", 32'(ok_a), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic GGA with fixed latency: first beat two clocks after the last checksum strobe
      gap_max = 0;
      model_stream("$GPGGA,1*4B");
      send_str("$GPGGA,1*4B");
      chk("latency_check_cycle", 32'(valid_a), 32'd0);
      @(posedge clk); #1;
      chk("latency_first_beat", 32'(valid_a), 32'd1);
      finish_sentence();
      gap_max = 2;

      run("$GPGGA,1*4C");
      rdy_mode = 2;
      run("$GPGGA,1*4b");
      rdy_mode = 0;
      run("$GPVTG*52");
      s = "$";
      for (int i = 0; i < MAX_LEN + 1; i++) s = {s, "X"};
      run(s);
      run("$GPGGA,1*4B");
      run("$GPG$GPGGA,1*4B");
      run("$GP\r");

      // exactly MAX_LEN body bytes is still legal
      s = "GPGGA,";
      while (s.len() < MAX_LEN) s = {s, "1"};
      rdy_mode = 1;
      run(sentence(s, 1'b0, 8'h00));

      // field index saturates at 31
      s = "GPGGA";
      for (int i = 0; i < 35; i++) s = {s, ","};
      s = {s, "9"};
      run(sentence(s, 1'b1, 8'h00));

      // reset while A is stalled mid-replay
      rdy_mode = 3;
      model_stream("$GPGGA,1*4B");
      send_str("$GPGGA,1*4B");
      t = 0;
      while (!valid_a && t < 200) begin @(posedge clk); #1; t++; end
      chk("stall_replay_started", 32'(valid_a), 32'd1);
      repeat (10) begin @(posedge clk); #1; end
      chk("b_drained_before_rst", 32'(qb.size()), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(valid_a), 32'd0);
      chk("rst_mid_ok", 32'(ok_a), 32'd0);
      qa.delete(); qb.delete(); ea.delete(); eb.delete();
      m_ok = 16'h0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rdy_mode = 0;
      @(posedge clk); #1;
      run("$GPGGA,1*4B");

      rdy_mode = 1;
      for (int n = 0; n < 40; n++) run(rand_sentence());

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
